// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_ctrl
//  Description : Sequencer for an external shift-add 32x32->64 unsigned
//                multiplier datapath. Accepts a one-cycle start request,
//                loads operands, runs the iteration sequence, requests the
//                result transfer and captures the product into hi/lo.
//                Optional macro MULDIV_EARLY_OUT_EN shortens the RUN phase
//                to the significant width of the multiplier operand.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl #(
    parameter logic [5:0] MULTU = 6'd25,
    parameter logic [5:0] OUT   = 6'b111111,
    parameter int         ITER  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  op,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [63:0] mul_result,
    output logic        mul_load,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic [5:0]  mul_signal,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int         c_CNT_W = $clog2(ITER + 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LOAD  = 3'd1;
    localparam logic [2:0] c_RUN   = 3'd2;
    localparam logic [2:0] c_XFER  = 3'd3;
    localparam logic [2:0] c_CAPT  = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_last_idx;
    logic               w_skip_run;
    logic               w_accept;
    logic               w_reject;
    logic [31:0]        r_mul_a;
    logic [31:0]        r_mul_b;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic               r_done;
    logic               r_err;
    logic               w_mul_load;
    logic [5:0]         w_mul_signal;

    // Requests are only looked at in IDLE; anything arriving while busy is dropped.
    assign w_accept = (r_state == c_IDLE) && start && (op == MULTU);
    assign w_reject = (r_state == c_IDLE) && start && (op != MULTU);

`ifdef MULDIV_EARLY_OUT_EN
    logic [5:0] w_run_len;

    // Run length is the position of the top set bit of the multiplier plus one.
    always_comb begin
        w_run_len = 6'd0;
        for (int i = 0; i < 32; i++) begin
            if (r_mul_b[i]) begin
                w_run_len = 6'(i + 1);
            end
        end
    end

    assign w_last_idx = c_CNT_W'(w_run_len - 6'd1);
    assign w_skip_run = (w_run_len == 6'd0);
`else
    assign w_last_idx = c_CNT_W'(ITER - 1);
    assign w_skip_run = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        w_next_state = r_state;
        w_mul_load   = 1'b0;
        w_mul_signal = 6'd0;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_next_state = c_LOAD;
                end
            end
            c_LOAD: begin
                w_mul_load   = 1'b1;
                w_next_state = w_skip_run ? c_XFER : c_RUN;
            end
            c_RUN: begin
                w_mul_signal = MULTU;
                if (r_cnt == w_last_idx) begin
                    w_next_state = c_XFER;
                end
            end
            c_XFER: begin
                w_mul_signal = OUT;
                w_next_state = c_CAPT;
            end
            c_CAPT: begin
                w_next_state = c_IDLE;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // Iteration counter: counts RUN cycles, back to zero on exit and elsewhere.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if ((r_state == c_RUN) && (r_cnt != w_last_idx)) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // Operand registers, loaded only when a legal request is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mul_a <= 32'd0;
            r_mul_b <= 32'd0;
        end else if (w_accept) begin
            r_mul_a <= dataA;
            r_mul_b <= dataB;
        end
    end

    // Product capture with aligned done pulse, plus illegal-op pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= (r_state == c_CAPT);
            r_err  <= w_reject;
            if (r_state == c_CAPT) begin
                r_hi <= mul_result[63:32];
                r_lo <= mul_result[31:0];
            end
        end
    end

    assign mul_load   = w_mul_load;
    assign mul_signal = w_mul_signal;
    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;
    assign busy       = (r_state != c_IDLE);
    assign done       = r_done;
    assign err        = r_err;
    assign hi         = r_hi;
    assign lo         = r_lo;

endmodule
`default_nettype wire
